// File: rtl/intr_ack_control_if.sv
// Bus bundle between the 8259 IRR block / CPU side and the interrupt-acknowledge controller.
// The master drives requests and INTA; the slave (the controller) answers.
interface intr_ack_control_if;
    logic       INT;
    logic [7:0] IRR;
    logic [7:0] mask;
    logic       INTA_n;
    logic [4:0] vectorBase;
    logic       autoEoi;
    logic       eoi;
    logic       specificEoi;
    logic [2:0] eoiLevel;

    logic       INTR;
    logic [1:0] intAcounter;
    logic [2:0] clearHighest;
    logic       clearStrobe;
    logic [7:0] ISR;
    logic [7:0] dataOut;
    logic       dataOutEn;

    modport master (
        output INT, IRR, mask, INTA_n, vectorBase, autoEoi, eoi, specificEoi, eoiLevel,
        input  INTR, intAcounter, clearHighest, clearStrobe, ISR, dataOut, dataOutEn
    );

    modport slave (
        input  INT, IRR, mask, INTA_n, vectorBase, autoEoi, eoi, specificEoi, eoiLevel,
        output INTR, intAcounter, clearHighest, clearStrobe, ISR, dataOut, dataOutEn
    );
endinterface

// File: rtl/intr_ack_control.sv
// 8259 interrupt-acknowledge controller: fixed-priority resolution against ISR,
// INTR generation, two-pulse INTA sequence, vector return and EOI/AEOI retirement.
module intr_ack_control #(
    parameter int         NUM_IR         = 8,
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic                clk,
    input  logic                reset,
    intr_ack_control_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK1 = 2'd2,
        S_ACK2 = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_inta_d;
    logic        r_intr;
    logic [1:0]  r_cnt;
    logic [2:0]  r_clr_lvl;
    logic        r_clr_stb;
    logic [7:0]  r_isr;
    logic [7:0]  r_dout;
    logic        r_doe;
    logic [2:0]  r_lvl;
    logic        r_spur;

    logic        w_intr_next;
    logic [1:0]  w_cnt_next;
    logic [2:0]  w_clr_lvl_next;
    logic        w_clr_stb_next;
    logic [7:0]  w_isr_next;
    logic [7:0]  w_dout_next;
    logic        w_doe_next;
    logic [2:0]  w_lvl_next;
    logic        w_spur_next;

    logic        w_fall;
    logic        w_rise;
    logic [7:0]  w_req;
    logic        w_req_any;
    logic [2:0]  w_req_lvl;
    logic [3:0]  w_isr_lvl;
    logic        w_set_en;
    logic        w_aeoi_clr;
    logic        w_spec;
    logic        w_nspec;
    logic [7:0]  w_isr_set;
    logic [7:0]  w_isr_clr;

    assign w_fall    = ~bus.INTA_n &  r_inta_d;
    assign w_rise    =  bus.INTA_n & ~r_inta_d;
    assign w_req     = bus.IRR & ~bus.mask;
    assign w_req_any = |w_req;

    // Walking from the top down leaves the lowest set index, i.e. highest priority.
    always_comb begin
        w_req_lvl = 3'd0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (w_req[i]) w_req_lvl = 3'(i);
        end
    end

    always_comb begin
        w_isr_lvl = 4'd8;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (r_isr[i]) w_isr_lvl = 4'(i);
        end
    end

    assign w_spec  = bus.specificEoi;
    assign w_nspec = bus.eoi & ~bus.specificEoi & (r_isr != 8'd0);

    // A bit being set this cycle wins over any clear aimed at the same bit.
    generate
        for (genvar gi = 0; gi < NUM_IR; gi++) begin : g_isr
            assign w_isr_set[gi] = w_set_en & (w_req_lvl == 3'(gi));
            assign w_isr_clr[gi] = (w_spec     & (bus.eoiLevel == 3'(gi)))
                                 | (w_nspec    & (w_isr_lvl    == 4'(gi)))
                                 | (w_aeoi_clr & (r_lvl        == 3'(gi)));
            assign w_isr_next[gi] = (r_isr[gi] & ~w_isr_clr[gi]) | w_isr_set[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_intr_next    = r_intr;
        w_cnt_next     = r_cnt;
        w_clr_lvl_next = r_clr_lvl;
        w_clr_stb_next = 1'b0;
        w_dout_next    = r_dout;
        w_doe_next     = r_doe;
        w_lvl_next     = r_lvl;
        w_spur_next    = r_spur;
        w_set_en       = 1'b0;
        w_aeoi_clr     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.INT && w_req_any && ({1'b0, w_req_lvl} < w_isr_lvl)) begin
                    w_state_next = S_REQ;
                    w_intr_next  = 1'b1;
                end
            end
            S_REQ: begin
                // INTR is held even if the request vanishes; the spurious path answers it.
                if (w_fall) begin
                    if (w_req_any) begin
                        w_lvl_next     = w_req_lvl;
                        w_set_en       = 1'b1;
                        w_clr_lvl_next = w_req_lvl;
                        w_clr_stb_next = 1'b1;
                        w_spur_next    = 1'b0;
                    end else begin
                        w_lvl_next  = SPURIOUS_LEVEL;
                        w_spur_next = 1'b1;
                    end
                    w_intr_next  = 1'b0;
                    w_cnt_next   = 2'd1;
                    w_state_next = S_ACK1;
                end
            end
            S_ACK1: begin
                if (w_fall) begin
                    w_dout_next  = {bus.vectorBase, r_lvl};
                    w_doe_next   = 1'b1;
                    w_cnt_next   = 2'd2;
                    w_state_next = S_ACK2;
                end
            end
            S_ACK2: begin
                if (w_rise) begin
                    w_doe_next   = 1'b0;
                    w_dout_next  = 8'd0;
                    w_cnt_next   = 2'd0;
                    w_aeoi_clr   = bus.autoEoi & ~r_spur;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inta_d  <= 1'b1;
            r_intr    <= 1'b0;
            r_cnt     <= 2'd0;
            r_clr_lvl <= 3'd0;
            r_clr_stb <= 1'b0;
            r_isr     <= 8'd0;
            r_dout    <= 8'd0;
            r_doe     <= 1'b0;
            r_lvl     <= 3'd0;
            r_spur    <= 1'b0;
        end else begin
            r_inta_d  <= bus.INTA_n;
            r_intr    <= w_intr_next;
            r_cnt     <= w_cnt_next;
            r_clr_lvl <= w_clr_lvl_next;
            r_clr_stb <= w_clr_stb_next;
            r_isr     <= w_isr_next;
            r_dout    <= w_dout_next;
            r_doe     <= w_doe_next;
            r_lvl     <= w_lvl_next;
            r_spur    <= w_spur_next;
        end
    end

    assign bus.INTR         = r_intr;
    assign bus.intAcounter  = r_cnt;
    assign bus.clearHighest = r_clr_lvl;
    assign bus.clearStrobe  = r_clr_stb;
    assign bus.ISR          = r_isr;
    assign bus.dataOut      = r_dout;
    assign bus.dataOutEn    = r_doe;

endmodule

// File: tb/tb_intr_ack_control.sv
// Scoreboard bench for intr_ack_control: directed stimulus queues expected output
// events; a negedge monitor pops and compares each observed output change.
module tb_intr_ack_control;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    intr_ack_control_if bus();

    intr_ack_control #(
        .NUM_IR         (8),
        .SPURIOUS_LEVEL (3'd7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {K_INTR, K_ISR, K_CNT, K_CLR, K_DOE} kind_t;
    typedef struct {
        kind_t      k;
        logic [8:0] v;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic void exp_ev(input kind_t k, input logic [8:0] v);
        ev_t e;
        e.k = k;
        e.v = v;
        exp_q.push_back(e);
    endfunction

    task automatic observe(input kind_t k, input logic [8:0] v, input string nm);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected event value %h, required no event", nm, v);
        end else begin
            e = exp_q.pop_front();
            if (e.k != k || e.v !== v)
                begin
                    errors++;
                    $display("FAIL %s actual kind %0d value %h, required kind %0d value %h",
                             nm, k, v, e.k, e.v);
                end
            else
                $display("event %s value %h ok", nm, v);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, req);
        end else begin
            $display("check %s value %h ok", nm, act);
        end
    endtask

    // Monitor: every change of a tracked output (and every strobe cycle) is one event.
    logic       p_intr = 1'b0;
    logic [7:0] p_isr  = 8'd0;
    logic [1:0] p_cnt  = 2'd0;
    logic [8:0] p_doe  = 9'd0;

    always @(negedge clk) begin
        if (bus.INTR !== p_intr)       observe(K_INTR, 9'(bus.INTR), "intr");
        if (bus.ISR !== p_isr)         observe(K_ISR, 9'(bus.ISR), "isr");
        if (bus.intAcounter !== p_cnt) observe(K_CNT, 9'(bus.intAcounter), "inta_count");
        if (bus.clearStrobe !== 1'b0)  observe(K_CLR, 9'(bus.clearHighest), "clear_highest");
        if ({bus.dataOutEn, bus.dataOut} !== p_doe)
            observe(K_DOE, {bus.dataOutEn, bus.dataOut}, "vector");
        p_intr = bus.INTR;
        p_isr  = bus.ISR;
        p_cnt  = bus.intAcounter;
        p_doe  = {bus.dataOutEn, bus.dataOut};
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic raise(input logic [7:0] irr);
        exp_ev(K_INTR, 9'd1);
        bus.IRR = irr;
        bus.INT = 1'b1;
        tick(1);
        chk("intr_latency", 32'(bus.INTR), 32'd1);
    endtask

    task automatic pulse_eoi(input logic spec, input logic [2:0] lvl);
        bus.eoi         = ~spec;
        bus.specificEoi = spec;
        bus.eoiLevel    = lvl;
        tick(1);
        bus.eoi         = 1'b0;
        bus.specificEoi = 1'b0;
        tick(1);
    endtask

    // Full two-pulse acknowledge; optional specific EOI in the same cycle as the first edge.
    task automatic do_ack(input logic isr_set, input logic [7:0] isr1, input logic [2:0] clr_lvl,
                          input logic [7:0] vec, input logic isr_clr_rise, input logic [7:0] isr2,
                          input logic spec_at_fall, input logic [2:0] spec_lvl);
        exp_ev(K_INTR, 9'd0);
        if (isr_set) exp_ev(K_ISR, 9'(isr1));
        exp_ev(K_CNT, 9'd1);
        if (isr_set) exp_ev(K_CLR, 9'(clr_lvl));
        bus.specificEoi = spec_at_fall;
        bus.eoiLevel    = spec_lvl;
        bus.INTA_n      = 1'b0;
        tick(1);
        bus.specificEoi = 1'b0;
        chk("count_after_first", 32'(bus.intAcounter), 32'd1);
        bus.IRR = 8'd0;
        bus.INT = 1'b0;
        tick(1);
        bus.INTA_n = 1'b1;
        tick(2);
        exp_ev(K_CNT, 9'd2);
        exp_ev(K_DOE, {1'b1, vec});
        bus.INTA_n = 1'b0;
        tick(2);
        chk("vector_held", 32'({bus.dataOutEn, bus.dataOut}), 32'({1'b1, vec}));
        if (isr_clr_rise) exp_ev(K_ISR, 9'(isr2));
        exp_ev(K_CNT, 9'd0);
        exp_ev(K_DOE, 9'd0);
        bus.INTA_n = 1'b1;
        tick(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.INT = 1'b0;  bus.IRR = 8'd0;  bus.mask = 8'd0;  bus.INTA_n = 1'b1;
        bus.vectorBase = 5'b01000;  bus.autoEoi = 1'b0;
        bus.eoi = 1'b0;  bus.specificEoi = 1'b0;  bus.eoiLevel = 3'd0;
        #1 reset = 1'b1;
        tick(3);
        chk("reset_intr",  32'(bus.INTR), 32'd0);
        chk("reset_count", 32'(bus.intAcounter), 32'd0);
        chk("reset_isr",   32'(bus.ISR), 32'd0);
        chk("reset_data",  32'(bus.dataOut), 32'd0);
        chk("reset_en",    32'(bus.dataOutEn), 32'd0);
        chk("reset_strobe", 32'(bus.clearStrobe), 32'd0);
        reset = 1'b0;
        tick(2);

        // Basic acknowledge of IR2
        raise(8'h04);
        do_ack(1'b1, 8'h04, 3'd2, 8'h42, 1'b0, 8'h00, 1'b0, 3'd0);
        exp_ev(K_ISR, 9'h000);
        pulse_eoi(1'b0, 3'd0);

        // Priority with mask: IR1 masked, IR2 wins
        bus.vectorBase = 5'b10101;
        bus.mask = 8'h02;
        raise(8'hFE);
        do_ack(1'b1, 8'h04, 3'd2, 8'hAA, 1'b0, 8'h00, 1'b0, 3'd0);
        exp_ev(K_ISR, 9'h000);
        pulse_eoi(1'b1, 3'd2);
        bus.mask = 8'h00;
        bus.vectorBase = 5'b01000;

        // Nesting
        raise(8'h10);
        do_ack(1'b1, 8'h10, 3'd4, 8'h44, 1'b0, 8'h00, 1'b0, 3'd0);
        bus.IRR = 8'h80;
        bus.INT = 1'b1;
        tick(3);
        chk("nest_lower_blocked", 32'(bus.INTR), 32'd0);
        raise(8'h02);
        do_ack(1'b1, 8'h12, 3'd1, 8'h41, 1'b0, 8'h00, 1'b0, 3'd0);
        exp_ev(K_ISR, 9'h010);
        pulse_eoi(1'b0, 3'd0);
        exp_ev(K_ISR, 9'h000);
        pulse_eoi(1'b1, 3'd4);

        // Non-specific EOI with empty ISR does nothing
        pulse_eoi(1'b0, 3'd0);
        chk("eoi_empty_isr", 32'(bus.ISR), 32'd0);

        // Spurious: IR5 disappears before the first INTA
        raise(8'h20);
        bus.IRR = 8'h00;
        bus.INT = 1'b0;
        tick(2);
        chk("spurious_intr_held", 32'(bus.INTR), 32'd1);
        do_ack(1'b0, 8'h00, 3'd0, 8'h47, 1'b0, 8'h00, 1'b0, 3'd0);
        chk("spurious_isr", 32'(bus.ISR), 32'd0);

        // Auto-EOI on IR0
        bus.autoEoi = 1'b1;
        raise(8'h01);
        do_ack(1'b1, 8'h01, 3'd0, 8'h40, 1'b1, 8'h00, 1'b0, 3'd0);
        bus.autoEoi = 1'b0;

        // Specific EOI for the bit being set in the same cycle: the set survives
        raise(8'h04);
        do_ack(1'b1, 8'h04, 3'd2, 8'h42, 1'b0, 8'h00, 1'b1, 3'd2);
        exp_ev(K_ISR, 9'h000);
        pulse_eoi(1'b0, 3'd0);

        // Reset in ACK2 while the vector is driven
        raise(8'h08);
        exp_ev(K_INTR, 9'd0);
        exp_ev(K_ISR, 9'h008);
        exp_ev(K_CNT, 9'd1);
        exp_ev(K_CLR, 9'd3);
        bus.INTA_n = 1'b0;
        tick(1);
        bus.IRR = 8'd0;
        bus.INT = 1'b0;
        tick(1);
        bus.INTA_n = 1'b1;
        tick(2);
        exp_ev(K_CNT, 9'd2);
        exp_ev(K_DOE, {1'b1, 8'h43});
        bus.INTA_n = 1'b0;
        tick(2);
        chk("pre_reset_en", 32'(bus.dataOutEn), 32'd1);
        exp_ev(K_ISR, 9'h000);
        exp_ev(K_CNT, 9'd0);
        exp_ev(K_DOE, 9'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_en",    32'(bus.dataOutEn), 32'd0);
        chk("async_reset_isr",   32'(bus.ISR), 32'd0);
        chk("async_reset_count", 32'(bus.intAcounter), 32'd0);
        chk("async_reset_intr",  32'(bus.INTR), 32'd0);
        bus.INTA_n = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        bus.INTA_n = 1'b0;
        tick(2);
        chk("idle_inta_count", 32'(bus.intAcounter), 32'd0);
        chk("idle_inta_en",    32'(bus.dataOutEn), 32'd0);
        bus.INTA_n = 1'b1;
        tick(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d pending events required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
